// File: rtl/sram_bus_responder.sv
// Bus slave that turns CPU bus requests into timed accesses on a 32-bit async SRAM.
// Latency: reads 2*WAIT_CYCLES+1 cycles (WAIT_CYCLES+1 single-word), writes WAIT_CYCLES+1.
// Backpressure: bus_stall stays high while a request is pending until the DONE cycle.
module sram_bus_responder #(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_CYCLES = 2,
  parameter int DUAL_READ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           bus_address,
  input  logic                  bus_read,
  input  logic                  bus_write,
  input  logic [3:0]            bus_mask,
  input  logic [31:0]           bus_data_wr,
  output logic [31:0]           bus_data_rd,
  output logic [31:0]           bus_data_rd_2,
  output logic                  bus_stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_out,
  output logic                  sram_data_oe,
  input  logic [31:0]           sram_data_in,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_wait_cnt;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_wa;
  logic                  w_unused_addr;

  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [31:0]           r_sram_data_out;
  logic                  r_sram_data_oe;
  logic                  r_sram_oe_n;
  logic                  r_sram_we_n;
  logic [3:0]            r_sram_be_n;
  logic [31:0]           r_data_rd;
  logic [31:0]           r_data_rd_2;

  // Word address; upper bits alias and the byte offset is irrelevant for word accesses.
  assign w_wa          = bus_address[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{bus_address[31:ADDR_WIDTH+2], bus_address[1:0]};
  assign w_last        = (r_wait_cnt == 4'(WAIT_CYCLES - 1));

  assign bus_stall     = (bus_read | bus_write) & (r_state != S_DONE) & ~rst;
  assign bus_data_rd   = r_data_rd;
  assign bus_data_rd_2 = r_data_rd_2;
  assign sram_addr     = r_sram_addr;
  assign sram_data_out = r_sram_data_out;
  assign sram_data_oe  = r_sram_data_oe;
  assign sram_oe_n     = r_sram_oe_n;
  assign sram_we_n     = r_sram_we_n;
  assign sram_be_n     = r_sram_be_n;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: write beats read in IDLE; DONE always returns to IDLE so a held request restarts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus_write)     w_state_nxt = (bus_mask != 4'h0) ? S_WR : S_DONE;
        else if (bus_read) w_state_nxt = S_RD1;
      end
      S_RD1:   if (w_last) w_state_nxt = (DUAL_READ != 0) ? S_RD2 : S_DONE;
      S_RD2:   if (w_last) w_state_nxt = S_DONE;
      S_WR:    if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Access-phase counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (rst)                                                   r_wait_cnt <= 4'd0;
    else if (w_state_nxt != r_state)                           r_wait_cnt <= 4'd0;
    else if (r_state == S_RD1 || r_state == S_RD2 || r_state == S_WR) r_wait_cnt <= r_wait_cnt + 4'd1;
    else                                                       r_wait_cnt <= 4'd0;
  end

  // SRAM pins are registered from the next state so they are glitch-free and stable
  // for the whole access window; read data is captured on the last cycle of each window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sram_addr     <= '0;
      r_sram_data_out <= 32'h0;
      r_sram_data_oe  <= 1'b0;
      r_sram_oe_n     <= 1'b1;
      r_sram_we_n     <= 1'b1;
      r_sram_be_n     <= 4'hF;
      r_data_rd       <= 32'h0;
      r_data_rd_2     <= 32'h0;
    end else begin
      r_sram_oe_n    <= ~((w_state_nxt == S_RD1) || (w_state_nxt == S_RD2));
      r_sram_we_n    <= ~(w_state_nxt == S_WR);
      r_sram_data_oe <= (w_state_nxt == S_WR);

      if (r_state == S_IDLE && w_state_nxt == S_WR) begin
        r_sram_addr     <= w_wa;
        r_sram_data_out <= bus_data_wr;
        r_sram_be_n     <= ~bus_mask;
      end else if (r_state == S_IDLE && w_state_nxt == S_RD1) begin
        r_sram_addr <= w_wa;
        r_sram_be_n <= 4'h0;
      end else if (r_state == S_RD1 && w_state_nxt == S_RD2) begin
        r_sram_addr <= r_sram_addr + ADDR_WIDTH'(1);
      end else if (w_state_nxt == S_DONE) begin
        r_sram_be_n <= 4'hF;
      end

      if (r_state == S_RD1 && w_last) begin
        r_data_rd <= sram_data_in;
        if (DUAL_READ == 0) r_data_rd_2 <= 32'h0;
      end
      if (r_state == S_RD2 && w_last) r_data_rd_2 <= sram_data_in;
    end
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder with behavioural async SRAM models.
// Two instances: DUAL_READ=1 (main) and DUAL_READ=0 (single-word read check).
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_sram_bus_responder;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0]   d_address, d_wdata, d_rdata, d_rdata_2, d_sram_dout, d_sram_din;
  logic          d_read, d_write, d_stall, d_sram_doe, d_oe_n, d_we_n;
  logic [3:0]    d_mask, d_be_n;
  logic [AW-1:0] d_sram_addr;

  logic [31:0]   s_address, s_wdata, s_rdata, s_rdata_2, s_sram_dout, s_sram_din;
  logic          s_read, s_write, s_stall, s_sram_doe, s_oe_n, s_we_n;
  logic [3:0]    s_mask, s_be_n;
  logic [AW-1:0] s_sram_addr;

  bit [31:0] mem_d [0:(1<<AW)-1];
  bit [31:0] mem_s [0:(1<<AW)-1];

  logic          pl_vld;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_dat;

  sram_bus_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2), .DUAL_READ(1)) u_dut (
    .clk(clk), .rst(rst),
    .bus_address(d_address), .bus_read(d_read), .bus_write(d_write),
    .bus_mask(d_mask), .bus_data_wr(d_wdata),
    .bus_data_rd(d_rdata), .bus_data_rd_2(d_rdata_2), .bus_stall(d_stall),
    .sram_addr(d_sram_addr), .sram_data_out(d_sram_dout), .sram_data_oe(d_sram_doe),
    .sram_data_in(d_sram_din), .sram_oe_n(d_oe_n), .sram_we_n(d_we_n), .sram_be_n(d_be_n)
  );

  sram_bus_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2), .DUAL_READ(0)) u_sgl (
    .clk(clk), .rst(rst),
    .bus_address(s_address), .bus_read(s_read), .bus_write(s_write),
    .bus_mask(s_mask), .bus_data_wr(s_wdata),
    .bus_data_rd(s_rdata), .bus_data_rd_2(s_rdata_2), .bus_stall(s_stall),
    .sram_addr(s_sram_addr), .sram_data_out(s_sram_dout), .sram_data_oe(s_sram_doe),
    .sram_data_in(s_sram_din), .sram_oe_n(s_oe_n), .sram_we_n(s_we_n), .sram_be_n(s_be_n)
  );

  // Async SRAM models: combinational read under oe_n, byte-masked write while we_n is low.
  assign d_sram_din = d_oe_n ? 32'h0 : mem_d[d_sram_addr];
  assign s_sram_din = s_oe_n ? 32'h0 : mem_s[s_sram_addr];

  always @(posedge clk) begin
    if (pl_vld) mem_d[pl_addr] <= pl_dat;
    else if (!d_we_n && d_sram_doe)
      for (int b = 0; b < 4; b++)
        if (!d_be_n[b]) mem_d[d_sram_addr][8*b +: 8] <= d_sram_dout[8*b +: 8];
  end

  always @(posedge clk) begin
    if (pl_vld) mem_s[pl_addr] <= pl_dat;
    else if (!s_we_n && s_sram_doe)
      for (int b = 0; b < 4; b++)
        if (!s_be_n[b]) mem_s[s_sram_addr][8*b +: 8] <= s_sram_dout[8*b +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-cycle trace of the main instance during one request.
  logic          tr_stall [0:63];
  logic          tr_oe_n  [0:63];
  logic          tr_we_n  [0:63];
  logic          tr_doe   [0:63];
  logic [3:0]    tr_be_n  [0:63];
  logic [AW-1:0] tr_addr  [0:63];
  logic [31:0]   tr_dout  [0:63];

  task automatic sample(input int k);
    tr_stall[k] = d_stall;
    tr_oe_n[k]  = d_oe_n;
    tr_we_n[k]  = d_we_n;
    tr_doe[k]   = d_sram_doe;
    tr_be_n[k]  = d_be_n;
    tr_addr[k]  = d_sram_addr;
    tr_dout[k]  = d_sram_dout;
  endtask

  function automatic int count_low(input bit use_we, input int n);
    int c;
    c = 0;
    for (int i = 0; i <= n; i++)
      if (use_we ? !tr_we_n[i] : !tr_oe_n[i]) c++;
    return c;
  endfunction

  // Present a request in cycle 0 and trace until stall drops (the DONE cycle).
  // With chain_rd the master immediately turns the request into a read of the same address.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wdata,
                         input bit chain_rd, output int done_cyc);
    int k;
    @(negedge clk);
    d_read = rd; d_write = wr; d_address = addr; d_mask = mask; d_wdata = wdata;
    #1;
    k = 0;
    sample(0);
    while (tr_stall[k] && k < 40) begin
      @(negedge clk); #1;
      k++;
      sample(k);
    end
    check("stall_released", {31'h0, tr_stall[k]}, 32'h0);
    done_cyc = k;
    if (chain_rd) begin d_write = 1'b0; d_read = 1'b1; end
    else          begin d_write = 1'b0; d_read = 1'b0; end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_vld = 1'b1; pl_addr = a; pl_dat = v;
    @(negedge clk);
    pl_vld = 1'b0;
  endtask

  initial begin
    int dc;
    int k;
    rst = 1'b1;
    pl_vld = 1'b0; pl_addr = '0; pl_dat = 32'h0;
    d_address = 32'h0; d_read = 1'b0; d_write = 1'b0; d_mask = 4'h0; d_wdata = 32'h0;
    s_address = 32'h0; s_read = 1'b0; s_write = 1'b0; s_mask = 4'h0; s_wdata = 32'h0;

    preload(20'h00100, 32'h11111111);
    preload(20'h00101, 32'h22222222);
    preload(20'hFFFFF, 32'hCAFEF00D);
    preload(20'h00000, 32'h0BADBEEF);

    // Reset state, with a request present to show stall is masked by reset.
    @(negedge clk);
    d_read = 1'b1; #1;
    check("rst_stall",  {31'h0, d_stall},    32'h0);
    check("rst_oe_n",   {31'h0, d_oe_n},     32'h1);
    check("rst_we_n",   {31'h0, d_we_n},     32'h1);
    check("rst_be_n",   {28'h0, d_be_n},     32'hF);
    check("rst_doe",    {31'h0, d_sram_doe}, 32'h0);
    check("rst_addr",   {12'h0, d_sram_addr}, 32'h0);
    check("rst_dout",   d_sram_dout,         32'h0);
    check("rst_rd",     d_rdata,             32'h0);
    check("rst_rd2",    d_rdata_2,           32'h0);
    d_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Dual-word read.
    run_req(1'b1, 1'b0, 32'h00000400, 4'h0, 32'h0, 1'b0, dc);
    check("rd_done_cyc", dc, 5);
    check("rd_stall_c4", {31'h0, tr_stall[4]}, 32'h1);
    check("rd_oe_cnt", count_low(1'b0, dc), 4);
    check("rd_oe_c1", {31'h0, tr_oe_n[1]}, 32'h0);
    check("rd_oe_c5", {31'h0, tr_oe_n[5]}, 32'h1);
    check("rd_addr_c1", {12'h0, tr_addr[1]}, 32'h100);
    check("rd_addr_c3", {12'h0, tr_addr[3]}, 32'h101);
    check("rd_data", d_rdata, 32'h11111111);
    check("rd_data2", d_rdata_2, 32'h22222222);

    // Masked write then read back.
    run_req(1'b0, 1'b1, 32'h00000010, 4'b0101, 32'hAABBCCDD, 1'b0, dc);
    check("wr_done_cyc", dc, 3);
    check("wr_be_n", {28'h0, tr_be_n[1]}, 32'hA);
    check("wr_we_cnt", count_low(1'b1, dc), 2);
    check("wr_doe_c1", {31'h0, tr_doe[1]}, 32'h1);
    check("wr_dout_c1", tr_dout[1], 32'hAABBCCDD);
    check("wr_oe_c1", {31'h0, tr_oe_n[1]}, 32'h1);
    check("wr_addr_c1", {12'h0, tr_addr[1]}, 32'h4);
    run_req(1'b1, 1'b0, 32'h00000010, 4'h0, 32'h0, 1'b0, dc);
    check("wr_readback", d_rdata, 32'h00BB00DD);

    // Wrap-around of the second word and upper-address aliasing.
    run_req(1'b1, 1'b0, 32'h003FFFFC, 4'h0, 32'h0, 1'b0, dc);
    check("wrap_addr_c1", {12'h0, tr_addr[1]}, 32'hFFFFF);
    check("wrap_addr_c3", {12'h0, tr_addr[3]}, 32'h0);
    check("wrap_rd", d_rdata, 32'hCAFEF00D);
    check("wrap_rd2", d_rdata_2, 32'h0BADBEEF);
    run_req(1'b1, 1'b0, 32'h80000400, 4'h0, 32'h0, 1'b0, dc);
    check("alias_addr_c1", {12'h0, tr_addr[1]}, 32'h100);
    check("alias_rd", d_rdata, 32'h11111111);
    check("alias_rd2", d_rdata_2, 32'h22222222);

    // Zero-mask write: immediate completion, no SRAM cycle.
    run_req(1'b0, 1'b1, 32'h00000020, 4'h0, 32'hDEADBEEF, 1'b0, dc);
    check("m0_done_cyc", dc, 1);
    check("m0_we_cnt", count_low(1'b1, dc), 0);
    check("m0_rd_hold", d_rdata, 32'h11111111);

    // Read and write together: write wins, read data untouched.
    run_req(1'b1, 1'b1, 32'h00000800, 4'hF, 32'h12345678, 1'b0, dc);
    check("rw_done_cyc", dc, 3);
    check("rw_we_cnt", count_low(1'b1, dc), 2);
    check("rw_oe_cnt", count_low(1'b0, dc), 0);
    check("rw_rd_hold", d_rdata, 32'h11111111);
    check("rw_rd2_hold", d_rdata_2, 32'h22222222);
    run_req(1'b1, 1'b0, 32'h00000800, 4'h0, 32'h0, 1'b0, dc);
    check("rw_readback", d_rdata, 32'h12345678);
    run_req(1'b1, 1'b0, 32'h00000020, 4'h0, 32'h0, 1'b0, dc);
    check("m0_readback", d_rdata, 32'h0);

    // Back-to-back write then read with the request held through DONE.
    run_req(1'b0, 1'b1, 32'h00000040, 4'hF, 32'h5A5A5A5A, 1'b1, dc);
    check("b2b_wr_done", dc, 3);
    check("b2b_done_doe", {31'h0, tr_doe[3]}, 32'h0);
    check("b2b_done_oe", {31'h0, tr_oe_n[3]}, 32'h1);
    check("b2b_done_we", {31'h0, tr_we_n[3]}, 32'h1);
    run_req(1'b1, 1'b0, 32'h00000040, 4'h0, 32'h0, 1'b0, dc);
    check("b2b_idle_stall", {31'h0, tr_stall[0]}, 32'h1);
    check("b2b_idle_oe", {31'h0, tr_oe_n[0]}, 32'h1);
    check("b2b_idle_doe", {31'h0, tr_doe[0]}, 32'h0);
    check("b2b_rd_done", dc, 5);
    check("b2b_rd_data", d_rdata, 32'h5A5A5A5A);

    // Reset in the middle of the second read word.
    @(negedge clk);
    d_read = 1'b1; d_address = 32'h00000400;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rd2_addr", {12'h0, d_sram_addr}, 32'h101);
    check("mid_rd2_oe", {31'h0, d_oe_n}, 32'h0);
    check("mid_rd1_data", d_rdata, 32'h11111111);
    rst = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_stall", {31'h0, d_stall}, 32'h0);
    check("mid_rst_oe", {31'h0, d_oe_n}, 32'h1);
    check("mid_rst_we", {31'h0, d_we_n}, 32'h1);
    check("mid_rst_be", {28'h0, d_be_n}, 32'hF);
    check("mid_rst_doe", {31'h0, d_sram_doe}, 32'h0);
    check("mid_rst_addr", {12'h0, d_sram_addr}, 32'h0);
    check("mid_rst_rd", d_rdata, 32'h0);
    check("mid_rst_rd2", d_rdata_2, 32'h0);
    rst = 1'b0;
    d_read = 1'b0;
    run_req(1'b1, 1'b0, 32'h00000400, 4'h0, 32'h0, 1'b0, dc);
    check("post_rst_done", dc, 5);
    check("post_rst_rd", d_rdata, 32'h11111111);

    // Single-word read instance.
    @(negedge clk);
    s_read = 1'b1; s_address = 32'h00000400;
    #1;
    k = 0;
    while (s_stall && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    check("sgl_stall_released", {31'h0, s_stall}, 32'h0);
    check("sgl_done_cyc", k, 3);
    check("sgl_rd", s_rdata, 32'h11111111);
    check("sgl_rd2", s_rdata_2, 32'h0);
    s_read = 1'b0;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
- Slave-side responder for the core's instruction/data bus: the other end of the master port the CPU top drives (address, read/write, byte mask, data_rd, data_rd_2, stall).
- Converts each bus request into timed accesses on a single-port 32-bit asynchronous SRAM.
- Returns two consecutive words per read (data_rd at address, data_rd_2 at address+4), as needed by the dual-issue fetch path.
- Holds stall high until the response is ready.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width. SRAM size is 2^ADDR_WIDTH words.
- WAIT_CYCLES, 2, clock cycles per SRAM access. Legal range 1..15.
- DUAL_READ, 1, when 1, reads fetch a second word into data_rd_2. When 0, the second access is skipped and data_rd_2 is 0.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- bus_address  in  32  byte address of request; bits [1:0] ignored
- bus_read  in  1  read request, held by master until stall low
- bus_write  in  1  write request, held by master until stall low
- bus_mask  in  4  byte enables for write; bit i = byte i
- bus_data_wr  in  32  write data
- bus_data_rd  out  32  word at address
- bus_data_rd_2  out  32  word at address+4
- bus_stall  out  1  request not yet complete
- sram_addr  out  ADDR_WIDTH  SRAM word address
- sram_data_out  out  32  data driven to SRAM
- sram_data_oe  out  1  1 = drive SRAM data pins (tri-state control at top)
- sram_data_in  in  32  data from SRAM pins
- sram_oe_n  out  1  SRAM output enable, active low
- sram_we_n  out  1  SRAM write enable, active low
- sram_be_n  out  4  SRAM byte enables, active low

Behaviour:
- Reset values: state=IDLE, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_data_oe=0, sram_addr=0, sram_data_out=0, bus_data_rd=0, bus_data_rd_2=0, wait counter=0. bus_stall=0 while rst=1.
- Reset mid-transaction: abort on the next edge and return to IDLE with the values above. A partial write may have landed in SRAM.
- Word address: wa = bus_address[ADDR_WIDTH+1:2]. Higher bits are ignored, so the address space aliases.
- Second word address: wa+1 modulo 2^ADDR_WIDTH. The last word wraps to word 0.
- bus_stall (combinational) = (bus_read | bus_write) & (state != DONE) & ~rst.
- IDLE:
  - bus_write=1 and bus_mask!=0: latch address, data and mask; go to WR.
  - bus_write=1 and bus_mask==0: go to DONE with no SRAM cycle.
  - bus_read=1 (and bus_write=0): latch address; go to RD1.
  - Both read and write asserted: write wins; read data registers hold their old values.
- RD1:
  - Drive sram_addr=wa, oe_n=0, data_oe=0 for WAIT_CYCLES cycles.
  - On the last cycle, capture sram_data_in into bus_data_rd.
  - Then go to RD2 if DUAL_READ, else to DONE with bus_data_rd_2 set to 0.
- RD2: same as RD1 with sram_addr=wa+1; capture into bus_data_rd_2; then go to DONE.
- WR:
  - Drive sram_addr=wa, sram_data_out=latched data, data_oe=1, we_n=0, be_n=~mask for WAIT_CYCLES cycles.
  - oe_n=1 throughout. Then go to DONE.
- DONE:
  - One cycle with all SRAM strobes inactive (oe_n=1, we_n=1, be_n=F, data_oe=0). This is the bus-turnaround gap.
  - bus_stall=0 and read data is valid this cycle; the master samples and advances.
  - Next state is IDLE unconditionally. A request present in the following cycle is treated as new, even if its address is unchanged.
- Read latency with DUAL_READ=1: a request first seen in cycle 0 (IDLE) has stall high in cycles 0..2*WAIT_CYCLES and low in cycle 2*WAIT_CYCLES+1.
- Read latency with DUAL_READ=0: stall low in cycle WAIT_CYCLES+1.
- Write latency: stall low in cycle WAIT_CYCLES+1. A mask==0 write has stall low in cycle 1.
- Wait counter: counts 0..WAIT_CYCLES-1 and resets to 0 on every state change.
- Read data registers hold their value outside DONE until the next capture.

Test Plan (WAIT_CYCLES=2, ADDR_WIDTH=20, DUAL_READ=1 unless stated):
- Read, dual word: SRAM[0x100]=0x11111111, SRAM[0x101]=0x22222222. Read at 0x00000400 -> stall high for 5 cycles, low in cycle 5; data_rd=0x11111111, data_rd_2=0x22222222; oe_n low in cycles 1-4.
- Masked write then read: write 0xAABBCCDD, mask=4'b0101 to 0x10 (old word 0) -> be_n=4'b1010, we_n low 2 cycles, stall low in cycle 3. Following read of 0x10 -> data_rd=0x00BB00DD.
- Wrap-around and aliasing: read at byte address 0x003FFFFC -> sram_addr 0xFFFFF then 0x00000. Read at 0x80000400 returns the same data as 0x400.
- Corner requests: write with mask=0 -> stall low in cycle 1, we_n never asserted. Read and write together -> write performed, data_rd unchanged.
- Back-to-back with turnaround: write, then read, held continuously -> DONE cycle between them with data_oe=0 and oe_n=1. The read is not merged into the write; stall goes high again in the cycle after DONE.
- Reset and DUAL_READ=0: assert rst during RD2 -> next cycle state IDLE, all strobes inactive, data_rd=0. With DUAL_READ=0, a read completes with stall low in cycle 3 and data_rd_2=0.
